ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 host-side receiver: synchronises and deglitches the raw PS2_CLK/PS2_DATA pads, deserialises 11-bit device-to-host frames, checks parity/framing, recovers from stalled frames by timeout, and buffers received bytes in a FWFT FIFO with a valid/ready handshake.
Sits between the board-level PS/2 pins and the keyboard/scancode decoder inside topEntity, in the CLK_25MHZ domain, held in reset while the DCM is unlocked.

Parameters:
SYNC_STAGES, 2, flops in each pad synchroniser (>=2)
FILTER_LEN, 8, consecutive identical synced PS2_CLK samples needed to change the filtered clock level (>=1)
TIMEOUT, 5000, CLK_25MHZ cycles without a filtered falling edge before an in-progress frame is aborted (200 us at 25 MHz)
FIFO_DEPTH, 4, bytes of receive buffering (power of two, >=2)

Ports:
CLK_25MHZ  in   1  system clock, all logic rising-edge
RESET      in   1  asynchronous, active-high reset
PS2_CLK    in   1  raw PS/2 clock pad (asynchronous)
PS2_DATA   in   1  raw PS/2 data pad (asynchronous)
RX_DATA    out  8  FIFO head byte; meaningful only while RX_VALID=1
RX_VALID   out  1  FIFO non-empty
RX_READY   in   1  consumer accepts head byte when RX_VALID&RX_READY
PARITY_ERR out  1  one-cycle pulse: frame discarded, bad odd parity
FRAME_ERR  out  1  one-cycle pulse: bad start/stop bit or timeout
OVERFLOW   out  1  one-cycle pulse: good byte dropped, FIFO full
BUSY       out  1  high while FSM is not IDLE

Behaviour:
- Reset (async assert, sync release): synchroniser flops and filtered clock =1, filter/timeout/bit counters =0, FSM=IDLE, FIFO empty; RX_DATA=0, RX_VALID=0, all pulses 0, BUSY=0.
- Synchroniser: SYNC_STAGES flops per pad; no other use of raw pads.
- Filter: counter increments while synced PS2_CLK differs from filtered level, clears otherwise; filtered level toggles when counter reaches FILTER_LEN-1 (counter then clears). Shorter glitches never reach the FSM.
- Edge: fall = filt_prev & ~filt; PS2_DATA (synced) sampled in the fall cycle.
- FSM, advances only on fall:
  IDLE: data=0 -> DATA, bitcnt=0; data=1 -> FRAME_ERR pulse, stay IDLE.
  DATA: shift right, sample into bit 7 (LSB first); after 8th bit -> PARITY.
  PARITY: store bit -> STOP.
  STOP: -> IDLE; stop=0 -> FRAME_ERR (priority over parity); else XOR(data,parity)=0 -> PARITY_ERR; else push byte.
- Timeout: counter cleared on every fall and in IDLE; when non-IDLE and counter reaches TIMEOUT-1 -> FRAME_ERR pulse, FSM=IDLE, partial byte discarded. Counter saturates, never wraps.
- Error pulses are registered: asserted the cycle after the causing fall/timeout, exactly one cycle wide.
- Latency: push registered in STOP-fall cycle; RX_VALID high next cycle if FIFO was empty.
- FIFO (FWFT): RX_DATA = head; pop when RX_VALID&RX_READY; count width clog2(FIFO_DEPTH)+1, pointers wrap mod FIFO_DEPTH.
- Push while full and no pop: byte dropped, OVERFLOW pulse, contents unchanged. Push and pop same cycle while full: both succeed, no OVERFLOW. Push and pop while empty: not possible (RX_VALID=0), push succeeds.
- RX_DATA holds last head value when empty (no requirement to clear beyond reset).
- Reset mid-frame or mid-drain: everything returns to reset values immediately; partial frame and FIFO contents lost.

Test Plan:
1. Frame 0x1C (start0, 0,0,1,1,1,0,0,0, parity0, stop1), PS2 bit period 2000 cycles, RX_READY=1 -> RX_VALID one cycle with RX_DATA=0x1C, no error pulses, BUSY low after stop.
2. Same frame with parity=1 -> PARITY_ERR exactly one cycle after stop fall, RX_VALID stays 0; stop=0 with parity=1 -> FRAME_ERR only.
3. 3-cycle low glitch on PS2_CLK (FILTER_LEN=8) mid-idle and mid-frame, then frame 0xF0 -> no extra bits sampled, 0xF0 received, no errors.
4. Stop device after 5 falling edges -> FRAME_ERR single pulse TIMEOUT cycles after last fall, BUSY drops; subsequent 0xAA received correctly.
5. RX_READY=0, send 0x01..0x05 (DEPTH=4) -> OVERFLOW pulse on fifth only; then RX_READY=1 drains 0x01,0x02,0x03,0x04 on consecutive cycles, RX_VALID falls after 4; also push-while-full-with-pop -> no OVERFLOW.
6. Assert RESET after 4 data bits with 1 byte queued -> all outputs 0 immediately, FIFO empty; after release, frame 0x55 received with RX_DATA=0x55.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//
// Host-side PS/2 receiver. The raw PS2_CLK/PS2_DATA pads are synchronised,
// the clock is deglitched by a run-length filter, and 11-bit device-to-host
// frames (start, 8 data LSB first, odd parity, stop) are deserialised by a
// small FSM on each filtered falling edge. Good bytes go into a first-word-
// fall-through FIFO; bad frames, stalled frames and dropped bytes are
// reported as one-cycle pulses.
//
// Ports
//   CLK_25MHZ   in      system clock, all logic on the rising edge
//   RESET       in      asynchronous, active-high reset
//   PS2_CLK     in      raw PS/2 clock pad (asynchronous)
//   PS2_DATA    in      raw PS/2 data pad (asynchronous)
//   RX_DATA     out [8] FIFO head byte, meaningful while RX_VALID=1
//   RX_VALID    out     FIFO non-empty
//   RX_READY    in      consumer accepts the head byte
//   PARITY_ERR  out     pulse: frame discarded, bad odd parity
//   FRAME_ERR   out     pulse: bad start/stop bit, or frame timeout
//   OVERFLOW    out     pulse: good byte dropped because the FIFO was full
//   BUSY        out     FSM is not IDLE
//   DBG_STATE   out [2] FSM state: 0=IDLE 1=DATA 2=PARITY 3=STOP
//
// Handshake: a byte is transferred on every rising edge where
// RX_VALID && RX_READY. RX_VALID never depends on RX_READY, RX_DATA is
// stable while RX_VALID is high and not accepted, and the consumer may hold
// RX_READY high permanently.
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT     = 5000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       OVERFLOW,
    output logic       BUSY,
    output logic [1:0] DBG_STATE
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TCW = $clog2(TIMEOUT) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] T_MAX    = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Pad synchronisers (idle bus level is high)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Clock deglitch: the filtered level only follows the synced clock
    // after FILTER_LEN consecutive differing samples.
    // ------------------------------------------------------------------
    logic           filt;
    logic           filt_prev;
    logic [FCW-1:0] filt_cnt;
    logic           fall;

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt;
            if (clk_s != filt) begin
                if (filt_cnt == FILT_MAX) begin
                    filt     <= clk_s;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FCW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = filt_prev & ~filt;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t         state, state_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shreg, shreg_n;
    logic           par_q, par_n;
    logic [TCW-1:0] tcnt;
    logic           timeout;
    logic           push_req;
    logic           perr_n;
    logic           ferr_n;

    assign timeout = (state != S_IDLE) && (tcnt == T_MAX);

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par_q   <= par_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par_q;
        push_req  = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!data_s) begin
                        state_n   = S_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
                S_DATA: begin
                    // LSB arrives first, so shift right and enter at bit 7
                    shreg_n   = {data_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_n   = data_s;
                    state_n = S_STOP;
                end
                S_STOP: begin
                    state_n = S_IDLE;
                    // a missing stop bit hides any parity result
                    if (!data_s) begin
                        ferr_n = 1'b1;
                    end else if (!(^{shreg, par_q})) begin
                        perr_n = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else if (timeout) begin
            state_n = S_IDLE;
            ferr_n  = 1'b1;
        end
    end

    // Stall timer: saturates so a long stall cannot wrap into a false frame
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            tcnt <= '0;
        end else if (state == S_IDLE || fall) begin
            tcnt <= '0;
        end else if (tcnt != T_MAX) begin
            tcnt <= tcnt + TCW'(1);
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          do_push;
    logic [7:0]    rx_data_q;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign RX_VALID = (count != '0);
    assign pop      = RX_VALID & RX_READY;
    // a pop in the same cycle frees the slot the push needs
    assign do_push  = push_req & (~full | pop);
    assign rd_next  = rd_ptr + AW'(1);

    always_ff @(posedge CLK_25MHZ) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered head: keeps the last head byte visible once the FIFO drains
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            rx_data_q <= '0;
        end else if (pop) begin
            if (count >= CW'(2)) begin
                rx_data_q <= mem[rd_next];
            end else if (do_push) begin
                rx_data_q <= shreg;
            end
        end else if (count == '0 && do_push) begin
            rx_data_q <= shreg;
        end
    end

    assign RX_DATA = rx_data_q;

    // ------------------------------------------------------------------
    // Registered status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_25MHZ or posedge RESET) begin
        if (RESET) begin
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            PARITY_ERR <= perr_n;
            FRAME_ERR  <= ferr_n;
            OVERFLOW   <= push_req & full & ~pop;
        end
    end

    assign BUSY      = (state != S_IDLE);
    assign DBG_STATE = state;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo: self-checking bench for ps2_rx_fifo.
// A PS/2 device model drives frames bit by bit; a monitor collects popped
// bytes and error pulses; a queue-based FIFO model decides which bytes are
// expected out, and which frames produce errors or overflow.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT     = 300;
    localparam int FIFO_DEPTH  = 4;
    localparam int HALF        = 40;   // half PS/2 bit period in clk cycles
    // pad edge -> FSM action -> registered output visible
    localparam int LAT         = SYNC_STAGES + FILTER_LEN + 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       RESET;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic       RX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       PARITY_ERR;
    logic       FRAME_ERR;
    logic       OVERFLOW;
    logic       BUSY;
    logic [1:0] DBG_STATE;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_rx_fifo #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK_25MHZ (clk),
        .RESET     (RESET),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .PARITY_ERR(PARITY_ERR),
        .FRAME_ERR (FRAME_ERR),
        .OVERFLOW  (OVERFLOW),
        .BUSY      (BUSY),
        .DBG_STATE (DBG_STATE)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0, n_wide = 0;
    int last_pop_cyc = 0, last_perr_cyc = 0, last_ferr_cyc = 0;
    int fall_cyc = 0;
    logic perr_d = 1'b0, ferr_d = 1'b0, ovf_d = 1'b0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] model_fifo[$];
    int         pop_cyc_q[$];

    // ---------------- monitor (samples on the falling edge) ----------------
    always @(negedge clk) begin
        if (!RESET) begin
            if (RX_VALID && RX_READY) begin
                got_q.push_back(RX_DATA);
                pop_cyc_q.push_back(cyc);
                last_pop_cyc = cyc;
            end
            if (PARITY_ERR) begin
                n_perr++;
                last_perr_cyc = cyc;
                if (perr_d) n_wide++;
            end
            if (FRAME_ERR) begin
                n_ferr++;
                last_ferr_cyc = cyc;
                if (ferr_d) n_wide++;
            end
            if (OVERFLOW) begin
                n_ovf++;
                if (ovf_d) n_wide++;
            end
        end
        perr_d = PARITY_ERR;
        ferr_d = FRAME_ERR;
        ovf_d  = OVERFLOW;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Device model: data changes while the clock is high, host samples on fall
    task automatic send_frame(input logic [10:0] bits, input int glitch,
                              input int n_falls, input logic rdy_at_stop);
        for (int i = 0; i < n_falls; i++) begin
            PS2_DATA = bits[i];
            tick(HALF);
            PS2_CLK  = 1'b0;
            fall_cyc = cyc;
            if (i == 10 && rdy_at_stop) begin
                // open RX_READY just before the push lands on a full FIFO
                tick(LAT - 1);
                RX_READY = 1'b1;
                tick(HALF - LAT + 1);
            end else begin
                tick(HALF);
            end
            PS2_CLK = 1'b1;
            if (glitch == i) begin
                tick(15);
                PS2_CLK = 1'b0;
                tick(3);
                PS2_CLK = 1'b1;
            end
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic compare_pops();
        check("pop_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("pop_data", got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        pop_cyc_q.delete();
    endtask

    task automatic drain(input bit want_consec);
        RX_READY = 1'b1;
        while (model_fifo.size() > 0) exp_q.push_back(model_fifo.pop_front());
        tick(12);
        if (want_consec) begin
            for (int k = 1; k < pop_cyc_q.size(); k++)
                check("drain_consecutive", pop_cyc_q[k] - pop_cyc_q[k-1], 1);
        end
        check("drain_valid_low", RX_VALID, 0);
        compare_pops();
    endtask

    // One full frame plus the FIFO model update and the checks
    task automatic run_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                             input logic rdy, input int glitch, input logic rdy_at_stop,
                             input logic e_perr, input logic e_ferr, input logic e_good);
        int p0, f0, o0;
        logic e_ovf;
        logic [10:0] bits;
        RX_READY = rdy;
        if (rdy) while (model_fifo.size() > 0) exp_q.push_back(model_fifo.pop_front());
        p0 = n_perr;
        f0 = n_ferr;
        o0 = n_ovf;
        bits = {stop, (~^d) ^ bad_par, d, 1'b0};
        send_frame(bits, glitch, 11, rdy_at_stop);
        e_ovf = 1'b0;
        if (e_good) begin
            if (rdy_at_stop) begin
                while (model_fifo.size() > 0) exp_q.push_back(model_fifo.pop_front());
                exp_q.push_back(d);
            end else if (rdy) begin
                exp_q.push_back(d);
            end else if (model_fifo.size() < FIFO_DEPTH) begin
                model_fifo.push_back(d);
            end else begin
                e_ovf = 1'b1;
            end
        end
        tick(30);
        check("parity_err_pulses", n_perr - p0, e_perr);
        check("frame_err_pulses", n_ferr - f0, e_ferr);
        check("overflow_pulses", n_ovf - o0, e_ovf);
        check("busy_after_frame", BUSY, 0);
        check("rx_valid_level", RX_VALID, model_fifo.size() != 0);
        if (model_fifo.size() != 0) check("rx_data_head", RX_DATA, model_fifo[0]);
        compare_pops();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] d;
        logic       bad_par;
        logic       stop;
        logic       rdy;
        int         glitch;
        logic       e_perr;
        logic       e_ferr;
        logic       e_good;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int lf;
        logic [7:0] rd;
        logic rbp, rst, rrdy;
        int rg;

        //           d      bp    stop  rdy   glitch perr  ferr  good
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, -1,    1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, -1,    1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h1C, 1'b1, 1'b0, 1'b1, -1,    1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h1C, 1'b0, 1'b0, 1'b1, -1,    1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hF0, 1'b0, 1'b1, 1'b1,  3,    1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hF0, 1'b0, 1'b1, 1'b1,  0,    1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b1, -1,    1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b1, -1,    1'b0, 1'b0, 1'b1};
        vecs[8] = '{8'h80, 1'b0, 1'b1, 1'b0,  5,    1'b0, 1'b0, 1'b1};
        vecs[9] = '{8'h7E, 1'b0, 1'b1, 1'b1, -1,    1'b0, 1'b0, 1'b1};

        // ---- reset state ----
        RESET = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; RX_READY = 1'b0;
        tick(3);
        check("reset_rx_data", RX_DATA, 0);
        check("reset_rx_valid", RX_VALID, 0);
        check("reset_parity_err", PARITY_ERR, 0);
        check("reset_frame_err", FRAME_ERR, 0);
        check("reset_overflow", OVERFLOW, 0);
        check("reset_busy", BUSY, 0);
        check("reset_state", DBG_STATE, 0);
        RESET = 1'b0;
        tick(20);

        // ---- idle glitches: 3 and 7 cycles filtered, 8 cycles passes ----
        f0 = n_ferr;
        PS2_CLK = 1'b0; tick(3); PS2_CLK = 1'b1; tick(40);
        PS2_CLK = 1'b0; tick(FILTER_LEN - 1); PS2_CLK = 1'b1; tick(40);
        check("idle_glitch_filtered", n_ferr - f0, 0);
        PS2_CLK = 1'b0; fall_cyc = cyc; tick(FILTER_LEN); PS2_CLK = 1'b1; tick(40);
        check("idle_fall_start_high", n_ferr - f0, 1);
        check("idle_fall_err_latency", last_ferr_cyc - fall_cyc, LAT);
        check("idle_fall_stays_idle", BUSY, 0);

        // ---- table-driven frames ----
        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop, vecs[i].rdy,
                      vecs[i].glitch, 1'b0, vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_good);
            if (vecs[i].e_good && vecs[i].rdy) check("valid_latency", last_pop_cyc - fall_cyc, LAT);
            if (vecs[i].e_perr) check("parity_err_latency", last_perr_cyc - fall_cyc, LAT);
            if (vecs[i].e_ferr) check("frame_err_latency", last_ferr_cyc - fall_cyc, LAT);
        end

        // ---- stalled frame: 5 falls then silence ----
        RX_READY = 1'b1;
        f0 = n_ferr;
        send_frame({1'b1, 1'b1, 8'hAA, 1'b0}, -1, 5, 1'b0);
        lf = fall_cyc;
        tick(20);
        check("stall_busy", BUSY, 1);
        check("stall_state_data", DBG_STATE, 1);
        check("stall_no_early_err", n_ferr - f0, 0);
        tick(TIMEOUT);
        check("timeout_pulse", n_ferr - f0, 1);
        check("timeout_latency", last_ferr_cyc - lf, TIMEOUT + LAT);
        check("timeout_busy_low", BUSY, 0);
        compare_pops();
        run_frame(8'hAA, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);

        // ---- overflow on the fifth byte, then drain ----
        for (int k = 1; k <= 5; k++)
            run_frame(8'(k), 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(1'b1);

        // ---- push into a full FIFO with a simultaneous pop ----
        for (int k = 1; k <= 4; k++)
            run_frame(8'(8'h10 + k), 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(8'h15, 1'b0, 1'b1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b1);

        // ---- reset mid-frame with a byte queued ----
        run_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame({1'b1, 1'b0, 8'h55, 1'b0}, -1, 5, 1'b0);
        tick(5);
        check("pre_reset_busy", BUSY, 1);
        RESET = 1'b1;
        #1;
        check("midreset_rx_valid", RX_VALID, 0);
        check("midreset_rx_data", RX_DATA, 0);
        check("midreset_busy", BUSY, 0);
        check("midreset_state", DBG_STATE, 0);
        model_fifo.delete();
        tick(5);
        RESET = 1'b0;
        tick(20);
        check("post_reset_empty", RX_VALID, 0);
        run_frame(8'h55, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(1'b0);

        // ---- randomized frames against the FIFO model ----
        for (int n = 0; n < 16; n++) begin
            rd   = 8'($urandom_range(0, 255));
            rbp  = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 7) != 0);
            rrdy = 1'($urandom_range(0, 1));
            rg   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            // odd parity rule: a missing stop bit wins over a parity error
            run_frame(rd, rbp, rst, rrdy, rg, 1'b0, rst & rbp, ~rst, rst & ~rbp);
        end
        drain(1'b0);

        check("pulse_width_one_cycle", n_wide, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
